// File: rtl/core_led_driver_if.sv
// Avalon-MM register port of the LED driver: word address, select, active-low write,
// and zero-latency read data.
interface core_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/core_led_driver.sv
// PWM LED driver: latches a PIO pattern and duty once per PWM period, drives led_out registered.
// Optional blink gating is compiled in with `define CORE_LED_DRIVER_BLINK_EN.
module core_led_driver #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    pattern_in,
  core_led_driver_if.slave    bus,
  output logic [WIDTH-1:0]    led_out
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [1:0] ADDR_DUTY = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_PAT  = 2'd2;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_reg;
  logic [PWM_BITS-1:0] duty_q;
  logic [WIDTH-1:0]    pat_q;
  logic [WIDTH-1:0]    drive_c;
  logic                en_q;
  logic                blink_q;
  logic                blink_phase;
  logic                blink_off_c;
  logic                wr_c;
  logic                boundary_c;

  assign wr_c       = bus.chipselect & ~bus.write_n;
  assign boundary_c = (pwm_cnt == PWM_MAX);

  // Every writedata bit is looked at somewhere only in some configurations.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // Period counter, per-period shadows, register file and the LED output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      pat_q    <= '0;
      duty_q   <= '0;
      duty_reg <= PWM_MAX;
      en_q     <= 1'b1;
      led_out  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      // Shadows load only here; a DUTY write on this same edge lands next period.
      if (boundary_c) begin
        pat_q  <= pattern_in;
        duty_q <= duty_reg;
      end
      if (wr_c && bus.address == ADDR_DUTY) duty_reg <= bus.writedata[PWM_BITS-1:0];
      if (wr_c && bus.address == ADDR_CTRL) en_q <= bus.writedata[0];
      led_out <= drive_c;
    end
  end

`ifdef CORE_LED_DRIVER_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;

  // Blink half-period timer; enabling BLINK restarts it in the lit phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_q     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (wr_c && bus.address == ADDR_CTRL && bus.writedata[1] && !blink_q) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
      if (wr_c && bus.address == ADDR_CTRL) blink_q <= bus.writedata[1];
    end
  end

  assign blink_off_c = blink_q & ~blink_phase;
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;

  assign blink_q     = 1'b0;
  assign blink_phase = 1'b0;
  assign blink_off_c = 1'b0;
`endif

  // Drive term: full-on at all-ones duty, otherwise lit while the counter is below duty.
  always_comb begin
    drive_c = '0;
    if (en_q && ((duty_q == PWM_MAX) || (pwm_cnt < duty_q))) drive_c = pat_q;
    if (blink_off_c) drive_c = '0;
  end

  // Zero-latency read mux; DUTY returns the programmed value, not the active shadow.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DUTY: bus.readdata[PWM_BITS-1:0] = duty_reg;
      ADDR_CTRL: bus.readdata[1:0] = {blink_q, en_q};
      ADDR_PAT:  bus.readdata[WIDTH-1:0] = pat_q;
      default: begin
        bus.readdata[15:8] = 8'(pwm_cnt);
        bus.readdata[0]    = blink_phase;
      end
    endcase
  end

endmodule

// File: tb/tb_core_led_driver.sv
// Randomized bench for core_led_driver against a period-level reference model.
module tb_core_led_driver;
  localparam int unsigned WIDTH     = 10;
  localparam int unsigned PWM_BITS  = 8;
  localparam int unsigned BLINK_DIV = 4;
  localparam int          PERIOD    = 256;
  localparam int          PMAX      = PERIOD - 1;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] pattern_in;
  logic [WIDTH-1:0] led_out;

  core_led_driver_if bus();

  core_led_driver #(
    .WIDTH     (WIDTH),
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .bus        (bus),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the block should hold after each clock edge.
  int               m_cnt;
  int               m_duty;
  int               m_duty_reg;
  int               m_bcnt;
  logic [WIDTH-1:0] m_pat;
  logic [WIDTH-1:0] m_led;
  bit               m_en;
  bit               m_blink;
  bit               m_phase;
  bit               m_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = 32'(m_duty_reg);
`ifdef CORE_LED_DRIVER_BLINK_EN
      2'd1: r = {30'd0, m_blink, m_en};
      2'd2: r = 32'(m_pat);
      default: r = (32'(m_cnt) << 8) | 32'(m_phase);
`else
      2'd1: r = {31'd0, m_en};
      2'd2: r = 32'(m_pat);
      default: r = 32'(m_cnt) << 8;
`endif
    endcase
    return r;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    logic [WIDTH-1:0] lit;
    bit               wr;
    wr = bus.chipselect && !bus.write_n;
    if (reset_n !== 1'b1) begin
      m_cnt = 0; m_pat = '0; m_duty = 0; m_led = '0;
      m_duty_reg = PMAX; m_en = 1'b1; m_blink = 1'b0;
      m_bcnt = 0; m_phase = 1'b1; m_valid = 1'b1;
      return;
    end
    lit = ((m_duty == PMAX) || (m_cnt < m_duty)) ? m_pat : '0;
    if (!m_en) lit = '0;
`ifdef CORE_LED_DRIVER_BLINK_EN
    if (m_blink && !m_phase) lit = '0;
    if (wr && bus.address == 2'd1 && bus.writedata[1] && !m_blink) begin
      m_bcnt = 0; m_phase = 1'b1;
    end else if (m_bcnt == int'(BLINK_DIV) - 1) begin
      m_bcnt = 0; m_phase = !m_phase;
    end else begin
      m_bcnt++;
    end
`endif
    m_led = lit;
    if (m_cnt == PMAX) begin
      m_pat  = pattern_in;
      m_duty = m_duty_reg;
    end
    if (wr && bus.address == 2'd0) m_duty_reg = int'(bus.writedata[7:0]);
    if (wr && bus.address == 2'd1) begin
      m_en = bus.writedata[0];
`ifdef CORE_LED_DRIVER_BLINK_EN
      m_blink = bus.writedata[1];
`endif
    end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      check_eq("led_out", 32'(led_out), 32'(m_led));
      check_eq("readdata", bus.readdata, exp_rdata(bus.address));
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic count_lit(input int n, input logic [WIDTH-1:0] val, output int hits);
    hits = 0;
    repeat (n) begin
      tick();
      if (led_out == val) hits++;
    end
  endtask

  initial begin
    int hits;
    reset_n = 1'b0; pattern_in = 10'h3FF;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd1; bus.writedata = '0;
    @(negedge clk);
    repeat (3) tick();
    reset_n = 1'b1;

    check_eq("rst_led", 32'(led_out), 32'h0);
    check_eq("rst_ctrl", bus.readdata, 32'h1);
    bus.address = 2'd0; #1;
    check_eq("rst_duty", bus.readdata, 32'hFF);
    bus.address = 2'd1;

    // First boundary after release lights everything one cycle later.
    for (int k = 1; k <= 257; k++) begin
      tick();
      if (k == 256) check_eq("boot_dark", 32'(led_out), 32'h0);
      if (k == 257) check_eq("boot_lit", 32'(led_out), 32'h3FF);
    end

    // 50% duty.
    pattern_in = 10'h155;
    bus_write(2'd0, 32'h80);
    repeat (2 * PERIOD) tick();
    count_lit(PERIOD, 10'h155, hits);
    check_eq("pwm50_lit", 32'(hits), 32'd128);
    count_lit(PERIOD, 10'h000, hits);
    check_eq("pwm50_dark", 32'(hits), 32'd128);

    // DUTY written on the boundary edge: one more period at the old duty, then dark.
    while (m_cnt != PMAX) tick();
    bus_write(2'd0, 32'h0);
    count_lit(PERIOD, 10'h155, hits);
    check_eq("bnd_old_duty", 32'(hits), 32'd128);
    count_lit(PERIOD, 10'h000, hits);
    check_eq("bnd_new_off", 32'(hits), 32'(PERIOD));

    // Mid-period pattern change is deferred to the next period.
    bus_write(2'd0, 32'hFF);
    pattern_in = 10'h001;
    repeat (PERIOD + 20) tick();
    while (m_cnt != 16) tick();
    pattern_in = 10'h200;
    count_lit(240, 10'h001, hits);
    check_eq("mid_old_pat", 32'(hits), 32'd240);
    tick();
    check_eq("mid_new_pat", 32'(led_out), 32'h200);

    // Disable mid-period.
    pattern_in = 10'h155;
    bus_write(2'd0, 32'h80);
    repeat (2 * PERIOD) tick();
    while (m_cnt != 16) tick();
    bus_write(2'd1, 32'h0);
    check_eq("dis_prev", 32'(led_out), 32'h155);
    tick();
    check_eq("dis_led", 32'(led_out), 32'h0);
    bus.address = 2'd2; #1;
    check_eq("dis_pat", bus.readdata, 32'h155);
    repeat (20) tick();
    bus_write(2'd1, 32'h1);

`ifdef CORE_LED_DRIVER_BLINK_EN
    bus_write(2'd0, 32'hFF);
    pattern_in = 10'h3FF;
    repeat (PERIOD + 10) tick();
    bus_write(2'd1, 32'h3);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_eq("blink", 32'(led_out), (((i - 1) / 4) % 2 == 0) ? 32'h3FF : 32'h0);
    end
    bus_write(2'd1, 32'h1);
`endif

    // Random traffic: register writes, pattern changes and occasional resets.
    repeat (4000) begin
      reset_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 63) == 0) pattern_in = WIDTH'($urandom);
      bus.chipselect = ($urandom_range(0, 3) == 0);
      bus.write_n    = $urandom_range(0, 1) == 1;
      bus.address    = 2'($urandom_range(0, 3));
      bus.writedata  = $urandom;
      if (bus.address == 2'd1) bus.writedata[0] = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset_n = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_led_driver.md
CORE_LED_DRIVER -- requirements
Module: core_led_driver

Interface
REQ-001 Parameter: WIDTH, 10, number of LED channels; matches the upstream PIO out_port width.
REQ-002 Parameter: PWM_BITS, 8, width of the PWM counter and duty register.
REQ-003 Parameter: BLINK_DIV, 25000000, clk cycles per blink half-period; minimum 2.
REQ-004 Port: clk  in  1  single clock; all logic is on its rising edge.
REQ-005 Port: reset_n  in  1  synchronous, active-low reset.
REQ-006 Port: pattern_in  in  WIDTH  LED pattern taken from the PIO out_port.
REQ-007 Port: address  in  2  Avalon-MM slave word address.
REQ-008 Port: chipselect  in  1  Avalon-MM slave select.
REQ-009 Port: write_n  in  1  Avalon-MM write strobe, active-low.
REQ-010 Port: writedata  in  32  Avalon-MM write data.
REQ-011 Port: readdata  out  32  Avalon-MM read data, combinational from address, zero-latency.
REQ-012 Port: led_out  out  WIDTH  registered LED drive, 1 = lit.

Function
REQ-013 Register map:
- 0 = DUTY, RW, bits [PWM_BITS-1:0].
- 1 = CTRL, RW: bit0 EN, bit1 BLINK.
- 2 = PATTERN, RO: currently latched pattern.
- 3 = STATUS, RO: bit0 blink_phase, bits [15:8] pwm_cnt.
REQ-014 Write acceptance: a write is accepted when chipselect=1, write_n=0, address selects a RW register; it takes effect on that clock edge. Writes to addresses 2 and 3 are ignored.
REQ-015 Read data: unused readdata bits read 0. DUTY reads back the written value, not the active shadow.
REQ-016 PWM counter: pwm_cnt is a free-running PWM_BITS counter, increments every cycle, wraps from all-ones to 0.
REQ-017 Period boundary: this is the cycle where pwm_cnt equals all-ones. At that edge, pattern_in is copied into pat_q and DUTY into duty_q; no mid-period changes.
REQ-018 Drive term: on = EN & pat_q[i] & ((duty_q == all-ones) | (pwm_cnt < duty_q)).
- duty_q=0 gives always off.
- duty_q=all-ones gives 100%.
- Otherwise duty_q/2^PWM_BITS.
REQ-019 Output register: led_out[i] registers the drive term, one cycle latency from pwm_cnt.
REQ-020 EN=0: forces led_out to 0 from the next cycle, independent of the period boundary. Counters keep running.
REQ-021 Simultaneous events: a DUTY write on a period-boundary cycle is not captured into duty_q. duty_q takes the old DUTY value; the new value applies at the next boundary.
REQ-022 pattern_in change: changes between boundaries are invisible on led_out until the next boundary, 2^PWM_BITS cycles max.

Reset
REQ-023 Reset values: while reset_n=0 at a clk edge, the following take these values:
- pwm_cnt=0, pat_q=0, duty_q=0, led_out=0.
- DUTY=all-ones, EN=1, BLINK=0.
- blink_cnt=0, blink_phase=1.
REQ-024 Reset mid-period: reset asserted mid-period aborts the period. After release, the first boundary occurs 2^PWM_BITS cycles later, so led_out stays 0 until then.
REQ-025 Reset timing: readdata reflects reset register values in the cycle after reset is sampled.

Configuration
REQ-026 Macro: CORE_LED_DRIVER_BLINK_EN.
REQ-027 Macro defined:
- blink_cnt counts 0..BLINK_DIV-1, wraps, and toggles blink_phase on wrap.
- With BLINK=1 and blink_phase=0, led_out is forced to 0 on the next cycle.
- A write of BLINK 0->1 clears blink_cnt and sets blink_phase=1.
REQ-028 Macro undefined: no blink_cnt logic exists. CTRL bit1 is not stored and reads 0. STATUS bit0 reads 0.

Verification
REQ-029 Reset and enable: reset, pattern_in=0x3FF, no writes -> led_out=0x3FF from cycle 257 after reset release; readdata @1 = 0x1.
REQ-030 50% duty: DUTY=0x80, pattern_in=0x155 -> each period, led_out=0x155 for exactly 128 cycles, then 0x000 for 128.
REQ-031 Mid-period change: pattern_in 0x001->0x200 at pwm_cnt=0x10 -> led_out bit0 stays driven to period end, then bit9 from the next period.
REQ-032 Boundary write: DUTY write 0x00 with pwm_cnt=0xFF -> next period uses the old duty; the following period is fully off.
REQ-033 Disable: CTRL=0 write mid-period -> led_out=0 one cycle later; pwm_cnt continues; readdata @2 still = pat_q.
REQ-034 Blink (macro on, BLINK_DIV=4): CTRL=0x3, DUTY=0xFF, pattern=0x3FF -> led_out alternates 0x3FF/0x000 every 4 cycles, starting lit.
